// File: rtl/multi_clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock divider.
// Configuration is carried at a fixed maximum width and narrowed inside each channel.
package multi_clk_div_pkg;

    localparam int MAX_W        = 32;
    localparam int DEF_PERIOD_C = 50000000;
    localparam int DEF_THR_C    = 25000000;

    typedef struct packed {
        logic [MAX_W-1:0] period;
        logic [MAX_W-1:0] thr;
    } chan_cfg_t;

    // Channel-select width; at least one bit even for a single channel.
    function automatic int chw(input int nch);
        return (nch <= 2) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow config, registered q/tick/pend.
// Latency: q/tick registered from next-state logic, so they track the held count.
// Backpressure: none; config writes are accepted every cycle and shadowed until the wrap.
module clk_div_chan
    import multi_clk_div_pkg::*;
#(
    parameter int N          = 26,
    parameter int DEF_PERIOD = DEF_PERIOD_C,
    parameter int DEF_THR    = DEF_THR_C
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      en,
    input  logic      sync,
    input  logic      wr,
    input  chan_cfg_t wr_cfg,
    output logic      q,
    output logic      tick,
    output logic      pend
);

    localparam chan_cfg_t DEF_CFG = '{period: MAX_W'(DEF_PERIOD), thr: MAX_W'(DEF_THR)};

    chan_cfg_t    act_q, act_d;
    chan_cfg_t    pnd_q, pnd_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic         pend_q, pend_d;
    logic         q_q, q_d;
    logic         tick_q, tick_d;
    logic         wrap;

    assign wrap = en && (MAX_W'(cnt_q) == act_q.period);

    always_comb begin
        act_d  = act_q;
        pnd_d  = pnd_q;
        pend_d = pend_q;
        cnt_d  = cnt_q + N'(1);

        if (wr) begin
            pnd_d = wr_cfg;
        end

        if (!en) begin
            // Idle channel: nothing is mid-period, so config lands immediately.
            act_d  = wr ? wr_cfg : pnd_q;
            pend_d = 1'b0;
            cnt_d  = '0;
        end else if (sync) begin
            // A write coinciding with sync stays shadowed for the following wrap.
            act_d  = pnd_q;
            pend_d = wr;
            cnt_d  = '0;
        end else if (wrap) begin
            act_d  = wr ? wr_cfg : pnd_q;
            pend_d = 1'b0;
            cnt_d  = '0;
        end else if (wr) begin
            pend_d = 1'b1;
        end

        q_d    = en && (MAX_W'(cnt_d) >= act_d.thr);
        tick_d = en && !sync && (MAX_W'(cnt_d) == act_d.period);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q  <= DEF_CFG;
            pnd_q  <= DEF_CFG;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            q_q    <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            act_q  <= act_d;
            pnd_q  <= pnd_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            q_q    <= q_d;
            tick_q <= tick_d;
        end
    end

    assign q    = q_q;
    assign tick = tick_q;
    assign pend = pend_q;

endmodule

// File: rtl/multi_clk_div.sv
// NCH-channel programmable clock divider; optional phase-align input under MULTI_CLK_DIV_SYNC_EN.
// Latency: one clock from en/cfg to registered q/tick; config applies at the period wrap.
// Backpressure: none; writes to cfg_ch >= NCH are dropped.
module multi_clk_div
    import multi_clk_div_pkg::*;
#(
    parameter  int N          = 26,
    parameter  int NCH        = 4,
    parameter  int DEF_PERIOD = DEF_PERIOD_C,
    parameter  int DEF_THR    = DEF_THR_C,
    localparam int CHW        = chw(NCH)
) (
    input  logic           clk,
    input  logic           reset_n,
`ifdef MULTI_CLK_DIV_SYNC_EN
    input  logic           sync,
`endif
    input  logic [NCH-1:0] en,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [N-1:0]   cfg_period,
    input  logic [N-1:0]   cfg_thr,
    output logic [NCH-1:0] cfg_pend,
    output logic [NCH-1:0] q,
    output logic [NCH-1:0] tick
);

    chan_cfg_t wr_cfg;
    logic      sync_i;

`ifdef MULTI_CLK_DIV_SYNC_EN
    assign sync_i = sync;
`else
    assign sync_i = 1'b0;
`endif

    assign wr_cfg.period = MAX_W'(cfg_period);
    assign wr_cfg.thr    = MAX_W'(cfg_thr);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic wr;
        assign wr = cfg_we && (cfg_ch == CHW'(i));

        clk_div_chan #(
            .N          (N),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_THR    (DEF_THR)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en[i]),
            .sync    (sync_i),
            .wr      (wr),
            .wr_cfg  (wr_cfg),
            .q       (q[i]),
            .tick    (tick[i]),
            .pend    (cfg_pend[i])
        );
    end

endmodule

// File: tb/tb_multi_clk_div.sv
// Directed bench for multi_clk_div (N=4, NCH=2, P=9, T=5): vector table plus corner sequences.
module tb_multi_clk_div;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] en;
    logic       cfg_we;
    logic       cfg_ch;
    logic [3:0] cfg_period;
    logic [3:0] cfg_thr;
    logic [1:0] cfg_pend;
    logic [1:0] q;
    logic [1:0] tick;
`ifdef MULTI_CLK_DIV_SYNC_EN
    logic       sync;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multi_clk_div #(
        .N          (4),
        .NCH        (2),
        .DEF_PERIOD (9),
        .DEF_THR    (5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef MULTI_CLK_DIV_SYNC_EN
        .sync       (sync),
`endif
        .en         (en),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_thr    (cfg_thr),
        .cfg_pend   (cfg_pend),
        .q          (q),
        .tick       (tick)
    );

    typedef struct {
        logic [1:0] en;
        logic       we;
        logic       ch;
        logic [3:0] p;
        logic [3:0] t;
        logic [1:0] q;
        logic [1:0] tk;
        logic [1:0] pd;
    } vec_t;

    vec_t vecs[$];

    function automatic void r(input logic [1:0] e, input logic [1:0] eq,
                              input logic [1:0] et, input logic [1:0] ep);
        vec_t v;
        v = '{en: e, we: 1'b0, ch: 1'b0, p: 4'd0, t: 4'd0, q: eq, tk: et, pd: ep};
        vecs.push_back(v);
    endfunction

    function automatic void w(input logic [1:0] e, input logic c, input logic [3:0] p,
                              input logic [3:0] t, input logic [1:0] eq,
                              input logic [1:0] et, input logic [1:0] ep);
        vec_t v;
        v = '{en: e, we: 1'b1, ch: c, p: p, t: t, q: eq, tk: et, pd: ep};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] e, input logic we, input logic c,
                       input logic [3:0] p, input logic [3:0] t);
        en         = e;
        cfg_we     = we;
        cfg_ch     = c;
        cfg_period = p;
        cfg_thr    = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ticks;

        // Release at cnt 0; default 9/5 pattern on ch0, ch1 idle.
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 1
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 2
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 3
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 4
        r(2'b01, 2'b01, 2'b00, 2'b00);  // 5
        r(2'b01, 2'b01, 2'b00, 2'b00);  // 6
        r(2'b01, 2'b01, 2'b00, 2'b00);  // 7
        r(2'b01, 2'b01, 2'b00, 2'b00);  // 8
        r(2'b01, 2'b01, 2'b01, 2'b00);  // 9  cnt 9
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 10 cnt 0
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 11
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 12
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 13
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 14 cnt 4
        // Shadowed write at cnt 4: old period finishes, then P=3/T=1.
        w(2'b01, 1'b0, 4'd3, 4'd1, 2'b01, 2'b00, 2'b01);  // 15 cnt 5
        r(2'b01, 2'b01, 2'b00, 2'b01);  // 16
        r(2'b01, 2'b01, 2'b00, 2'b01);  // 17
        r(2'b01, 2'b01, 2'b00, 2'b01);  // 18
        r(2'b01, 2'b01, 2'b01, 2'b01);  // 19 cnt 9
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 20 wrap, new cfg
        r(2'b01, 2'b01, 2'b00, 2'b00);  // 21
        r(2'b01, 2'b01, 2'b00, 2'b00);  // 22
        r(2'b01, 2'b01, 2'b01, 2'b00);  // 23 cnt 3
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 24 cnt 0
        // Two writes before the wrap; only P=7/T=2 survives.
        w(2'b01, 1'b0, 4'd5, 4'd2, 2'b01, 2'b00, 2'b01);  // 25
        w(2'b01, 1'b0, 4'd7, 4'd2, 2'b01, 2'b00, 2'b01);  // 26
        r(2'b01, 2'b01, 2'b01, 2'b01);  // 27 cnt 3
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 28 wrap
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 29 cnt 1
        r(2'b01, 2'b01, 2'b00, 2'b00);  // 30 cnt 2
        r(2'b01, 2'b01, 2'b00, 2'b00);  // 31
        r(2'b01, 2'b01, 2'b00, 2'b00);  // 32
        r(2'b01, 2'b01, 2'b00, 2'b00);  // 33
        r(2'b01, 2'b01, 2'b00, 2'b00);  // 34
        r(2'b01, 2'b01, 2'b01, 2'b00);  // 35 cnt 7
        // Write in the wrap cycle: applied there, pend never set.
        w(2'b01, 1'b0, 4'd9, 4'd5, 2'b00, 2'b00, 2'b00);  // 36
        // Write to idle ch1 lands immediately.
        w(2'b01, 1'b1, 4'd1, 4'd1, 2'b00, 2'b00, 2'b00);  // 37 ch0 cnt 1
        r(2'b11, 2'b10, 2'b10, 2'b00);  // 38
        r(2'b11, 2'b00, 2'b00, 2'b00);  // 39
        r(2'b11, 2'b10, 2'b10, 2'b00);  // 40
        r(2'b11, 2'b01, 2'b00, 2'b00);  // 41 ch0 cnt 5
        r(2'b11, 2'b11, 2'b10, 2'b00);  // 42
        r(2'b11, 2'b01, 2'b00, 2'b00);  // 43 ch0 cnt 7
        r(2'b11, 2'b11, 2'b10, 2'b00);  // 44
        r(2'b11, 2'b01, 2'b01, 2'b00);  // 45 ch0 cnt 9
        r(2'b11, 2'b10, 2'b10, 2'b00);  // 46
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 47 ch1 off, ch0 cnt 1
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 48
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 49
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 50
        r(2'b01, 2'b01, 2'b00, 2'b00);  // 51 cnt 5
        r(2'b01, 2'b01, 2'b00, 2'b00);  // 52 cnt 6
        // Disable at cnt 6, then re-enable with a full low phase.
        r(2'b00, 2'b00, 2'b00, 2'b00);  // 53
        r(2'b00, 2'b00, 2'b00, 2'b00);  // 54
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 55 cnt 1
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 56
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 57
        r(2'b01, 2'b00, 2'b00, 2'b00);  // 58 cnt 4
        r(2'b01, 2'b01, 2'b00, 2'b00);  // 59 cnt 5

        reset_n    = 1'b1;
        en         = 2'b00;
        cfg_we     = 1'b0;
        cfg_ch     = 1'b0;
        cfg_period = 4'd0;
        cfg_thr    = 4'd0;
`ifdef MULTI_CLK_DIV_SYNC_EN
        sync       = 1'b0;
`endif
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset q", 32'(q), 32'd0);
        chk("reset tick", 32'(tick), 32'd0);
        chk("reset pend", 32'(cfg_pend), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].en, vecs[i].we, vecs[i].ch, vecs[i].p, vecs[i].t);
            chk($sformatf("row%0d q", i + 1), 32'(q), 32'(vecs[i].q));
            chk($sformatf("row%0d tick", i + 1), 32'(tick), 32'(vecs[i].tk));
            chk($sformatf("row%0d pend", i + 1), 32'(cfg_pend), 32'(vecs[i].pd));
        end

        // T=0: q held high on ch1.
        cyc(2'b01, 1'b1, 1'b1, 4'd9, 4'd0);
        chk("thr0 pend", 32'(cfg_pend), 32'd0);
        for (int k = 0; k < 12; k++) begin
            cyc(2'b11, 1'b0, 1'b0, 4'd0, 4'd0);
            chk($sformatf("thr0 q1 k%0d", k), 32'(q[1]), 32'd1);
        end

        // T beyond P: q held low, tick once per 10 clocks.
        cyc(2'b01, 1'b1, 1'b1, 4'd9, 4'd12);
        chk("thr12 pend", 32'(cfg_pend), 32'd0);
        ticks = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(2'b11, 1'b0, 1'b0, 4'd0, 4'd0);
            chk($sformatf("thr12 q1 k%0d", k), 32'(q[1]), 32'd0);
            ticks += int'(tick[1]);
        end
        chk("thr12 tick count", 32'(ticks), 32'd1);

        // P=0: tick every cycle.
        cyc(2'b01, 1'b1, 1'b1, 4'd0, 4'd0);
        for (int k = 0; k < 6; k++) begin
            cyc(2'b11, 1'b0, 1'b0, 4'd0, 4'd0);
            chk($sformatf("p0 tick1 k%0d", k), 32'(tick[1]), 32'd1);
        end

        // Async reset mid-period with a pending write on ch0.
        cyc(2'b00, 1'b0, 1'b0, 4'd0, 4'd0);
        repeat (5) cyc(2'b01, 1'b0, 1'b0, 4'd0, 4'd0);
        cyc(2'b01, 1'b1, 1'b0, 4'd3, 4'd1);
        cfg_we = 1'b0;
        chk("pre-reset q", 32'(q), 32'd1);
        chk("pre-reset pend", 32'(cfg_pend), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset q", 32'(q), 32'd0);
        chk("async reset pend", 32'(cfg_pend), 32'd0);
        #2 reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc(2'b01, 1'b0, 1'b0, 4'd0, 4'd0);
            chk($sformatf("post-reset q0 k%0d", k), 32'(q[0]), 32'((k >= 5 && k <= 9) ? 1 : 0));
            chk($sformatf("post-reset tick0 k%0d", k), 32'(tick[0]), 32'((k == 9) ? 1 : 0));
            chk($sformatf("post-reset pend k%0d", k), 32'(cfg_pend), 32'd0);
        end

`ifdef MULTI_CLK_DIV_SYNC_EN
        // Offset the channels, then sync realigns both to cnt 0 with no tick.
        repeat (2) cyc(2'b01, 1'b0, 1'b0, 4'd0, 4'd0);
        repeat (2) cyc(2'b11, 1'b0, 1'b0, 4'd0, 4'd0);
        sync = 1'b1;
        cyc(2'b11, 1'b0, 1'b0, 4'd0, 4'd0);
        sync = 1'b0;
        chk("sync tick", 32'(tick), 32'd0);
        chk("sync q", 32'(q), 32'd0);
        repeat (8) cyc(2'b11, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("sync pre-wrap tick", 32'(tick), 32'd0);
        cyc(2'b11, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("sync aligned tick", 32'(tick), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
